// File: rtl/i_decode_if.sv
// Bundle between the IF/ID register, the writeback port and the ID/EX register.
// The slave side is the decode stage; the master side drives the pipeline inputs.
interface i_decode_if;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_npc;
   logic        ex_mem_pc_src;
   logic        mem_wb_reg_write;
   logic [4:0]  mem_wb_write_reg;
   logic [31:0] mem_wb_write_data;

   logic [31:0] id_ex_npc;
   logic [31:0] id_ex_rd1;
   logic [31:0] id_ex_rd2;
   logic [31:0] id_ex_imm;
   logic [4:0]  id_ex_rt;
   logic [4:0]  id_ex_rd;
   logic [1:0]  id_ex_wb;
   logic [2:0]  id_ex_m;
   logic [3:0]  id_ex_ex;
   logic        stall;

   modport slave (
      input  if_id_instr, if_id_npc, ex_mem_pc_src,
      input  mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
      output id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm,
      output id_ex_rt, id_ex_rd, id_ex_wb, id_ex_m, id_ex_ex, stall
   );

   modport master (
      output if_id_instr, if_id_npc, ex_mem_pc_src,
      output mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
      input  id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_imm,
      input  id_ex_rt, id_ex_rd, id_ex_wb, id_ex_m, id_ex_ex, stall
   );
endinterface

// File: rtl/i_decode.sv
// MIPS-style instruction decode stage: register file, control decode,
// load-use hazard detection and the ID/EX pipeline register.
module i_decode #(
   parameter bit BYPASS = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   i_decode_if.slave  bus
);

   logic [31:0] rf_reg [32];

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [5:0]  opcode;
   logic        wr_hit;
   logic [31:0] rd1_next;
   logic [31:0] rd2_next;
   logic [1:0]  wb_next;
   logic [2:0]  m_next;
   logic [3:0]  ex_next;
   logic        stall_comb;
   logic        bubble;

   logic [31:0] id_ex_npc_reg;
   logic [31:0] id_ex_rd1_reg;
   logic [31:0] id_ex_rd2_reg;
   logic [31:0] id_ex_imm_reg;
   logic [4:0]  id_ex_rt_reg;
   logic [4:0]  id_ex_rd_reg;
   logic [1:0]  id_ex_wb_reg;
   logic [2:0]  id_ex_m_reg;
   logic [3:0]  id_ex_ex_reg;

   assign rs     = bus.if_id_instr[25:21];
   assign rt     = bus.if_id_instr[20:16];
   assign opcode = bus.if_id_instr[31:26];
   assign wr_hit = bus.mem_wb_reg_write && (bus.mem_wb_write_reg != 5'd0);

   // Entry 0 shares the loop but wr_hit excludes index 0, so it stays at zero.
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_rf
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rf_reg[gi] <= '0;
            end else if (wr_hit && (bus.mem_wb_write_reg == 5'(gi))) begin
               rf_reg[gi] <= bus.mem_wb_write_data;
            end
         end
      end
   endgenerate

   always_comb begin
      rd1_next = rf_reg[rs];
      rd2_next = rf_reg[rt];
      if (BYPASS && wr_hit && (bus.mem_wb_write_reg == rs)) begin
         rd1_next = bus.mem_wb_write_data;
      end
      if (BYPASS && wr_hit && (bus.mem_wb_write_reg == rt)) begin
         rd2_next = bus.mem_wb_write_data;
      end
   end

   always_comb begin
      wb_next = 2'b00;
      m_next  = 3'b000;
      ex_next = 4'b0000;
      case (opcode)
         6'h00: begin wb_next = 2'b10; m_next = 3'b000; ex_next = 4'b1100; end
         6'h23: begin wb_next = 2'b11; m_next = 3'b010; ex_next = 4'b0001; end
         6'h2B: begin wb_next = 2'b00; m_next = 3'b001; ex_next = 4'b0001; end
         6'h04: begin wb_next = 2'b00; m_next = 3'b100; ex_next = 4'b0010; end
         default: begin wb_next = 2'b00; m_next = 3'b000; ex_next = 4'b0000; end
      endcase
   end

   // A load in ID/EX whose destination feeds the instruction now in IF/ID.
   assign stall_comb = !rst && id_ex_m_reg[1] && (id_ex_rt_reg != 5'd0) &&
                       ((id_ex_rt_reg == rs) || (id_ex_rt_reg == rt));
   assign bubble     = bus.ex_mem_pc_src || stall_comb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_npc_reg <= '0;
         id_ex_rd1_reg <= '0;
         id_ex_rd2_reg <= '0;
         id_ex_imm_reg <= '0;
         id_ex_rt_reg  <= '0;
         id_ex_rd_reg  <= '0;
         id_ex_wb_reg  <= '0;
         id_ex_m_reg   <= '0;
         id_ex_ex_reg  <= '0;
      end else begin
         id_ex_npc_reg <= bus.if_id_npc;
         id_ex_rd1_reg <= rd1_next;
         id_ex_rd2_reg <= rd2_next;
         id_ex_imm_reg <= {{16{bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
         id_ex_rt_reg  <= rt;
         id_ex_rd_reg  <= bus.if_id_instr[15:11];
         id_ex_wb_reg  <= bubble ? 2'b00   : wb_next;
         id_ex_m_reg   <= bubble ? 3'b000  : m_next;
         id_ex_ex_reg  <= bubble ? 4'b0000 : ex_next;
      end
   end

   assign bus.id_ex_npc = id_ex_npc_reg;
   assign bus.id_ex_rd1 = id_ex_rd1_reg;
   assign bus.id_ex_rd2 = id_ex_rd2_reg;
   assign bus.id_ex_imm = id_ex_imm_reg;
   assign bus.id_ex_rt  = id_ex_rt_reg;
   assign bus.id_ex_rd  = id_ex_rd_reg;
   assign bus.id_ex_wb  = id_ex_wb_reg;
   assign bus.id_ex_m   = id_ex_m_reg;
   assign bus.id_ex_ex  = id_ex_ex_reg;
   assign bus.stall     = stall_comb;

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: two instances (forwarding on and off) against a
// behavioural pipeline model, plus directed literal checks.
module tb_i_decode;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
   } idex_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic [31:0] npc = '0;
   logic        pcsrc = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wreg = '0;
   logic [31:0] wdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   i_decode_if bus1 ();
   i_decode_if bus0 ();

   assign bus1.if_id_instr       = instr;
   assign bus1.if_id_npc         = npc;
   assign bus1.ex_mem_pc_src     = pcsrc;
   assign bus1.mem_wb_reg_write  = we;
   assign bus1.mem_wb_write_reg  = wreg;
   assign bus1.mem_wb_write_data = wdata;
   assign bus0.if_id_instr       = instr;
   assign bus0.if_id_npc         = npc;
   assign bus0.ex_mem_pc_src     = pcsrc;
   assign bus0.mem_wb_reg_write  = we;
   assign bus0.mem_wb_write_reg  = wreg;
   assign bus0.mem_wb_write_data = wdata;

   i_decode #(.BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   i_decode #(.BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   idex_t got1, got0;
   assign got1 = {bus1.id_ex_npc, bus1.id_ex_rd1, bus1.id_ex_rd2, bus1.id_ex_imm,
                  bus1.id_ex_rt, bus1.id_ex_rd, bus1.id_ex_wb, bus1.id_ex_m, bus1.id_ex_ex};
   assign got0 = {bus0.id_ex_npc, bus0.id_ex_rd1, bus0.id_ex_rd2, bus0.id_ex_imm,
                  bus0.id_ex_rt, bus0.id_ex_rd, bus0.id_ex_wb, bus0.id_ex_m, bus0.id_ex_ex};

   // ---------------- behavioural model ----------------
   logic [31:0] m_rf [32];
   idex_t       m_ex [2];

   function automatic logic [8:0] ctrl_of(input logic [5:0] op);
      case (op)
         6'h00:   return 9'b10_000_1100;
         6'h23:   return 9'b11_010_0001;
         6'h2B:   return 9'b00_001_0001;
         6'h04:   return 9'b00_100_0010;
         default: return 9'b0;
      endcase
   endfunction

   function automatic logic model_stall(input idex_t cur, input logic [31:0] ins);
      return cur.m[1] && (cur.rt != 5'd0) &&
             ((cur.rt == ins[25:21]) || (cur.rt == ins[20:16]));
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] idx, input logic fwd);
      if (idx == 5'd0) return 32'd0;
      if (fwd && we && (wreg == idx)) return wdata;
      return m_rf[idx];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
         m_ex[0] = '0;
         m_ex[1] = '0;
      end else begin
         idex_t nx [2];
         logic [8:0] c;
         for (int b = 0; b < 2; b++) begin
            c = ctrl_of(instr[31:26]);
            if (pcsrc || model_stall(m_ex[b], instr)) c = '0;
            nx[b].npc = npc;
            nx[b].rd1 = model_read(instr[25:21], b == 1);
            nx[b].rd2 = model_read(instr[20:16], b == 1);
            nx[b].imm = {{16{instr[15]}}, instr[15:0]};
            nx[b].rt  = instr[20:16];
            nx[b].rd  = instr[15:11];
            {nx[b].wb, nx[b].m, nx[b].ex} = c;
         end
         if (we && wreg != 5'd0) m_rf[wreg] = wdata;
         m_ex[0] = nx[0];
         m_ex[1] = nx[1];
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input idex_t g, input idex_t e);
      cmp({tag, ".npc"}, g.npc, e.npc);
      cmp({tag, ".rd1"}, g.rd1, e.rd1);
      cmp({tag, ".rd2"}, g.rd2, e.rd2);
      cmp({tag, ".imm"}, g.imm, e.imm);
      cmp({tag, ".rt"},  32'(g.rt), 32'(e.rt));
      cmp({tag, ".rd"},  32'(g.rd), 32'(e.rd));
      cmp({tag, ".wb"},  32'(g.wb), 32'(e.wb));
      cmp({tag, ".m"},   32'(g.m),  32'(e.m));
      cmp({tag, ".ex"},  32'(g.ex), 32'(e.ex));
   endtask

   // Single compare process: every falling edge, both instances vs the model.
   always @(negedge clk) begin
      logic exp_stall;
      exp_stall = !rst && model_stall(m_ex[1], instr);
      cmp_all("model.bypass1", got1, m_ex[1]);
      cmp_all("model.bypass0", got0, m_ex[0]);
      cmp("model.stall1", 32'(bus1.stall), 32'(exp_stall));
      cmp("model.stall0", 32'(bus0.stall), 32'(exp_stall));
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic pc_src,
                        input logic w, input logic [4:0] wr, input logic [31:0] wd);
      instr = ins;
      npc   = npc + 32'd4;
      pcsrc = pc_src;
      we    = w;
      wreg  = wr;
      wdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] NOP = 32'hFC00_0000;

   initial begin
      tick();
      tick();
      cmp("reset.all_zero", 32'(|got1), 32'd0);
      cmp("reset.stall",    32'(bus1.stall), 32'd0);
      rst = 1'b0;

      // r5 = 0xAA, then add rs=5 rt=0
      drive(NOP, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
      tick();
      drive(rtype(5'd5, 5'd0, 5'd3), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("add.rd1", got1.rd1, 32'h0000_00AA);
      cmp("add.rd2", got1.rd2, 32'd0);
      cmp("add.wb",  32'(got1.wb), 32'd2);
      cmp("add.ex",  32'(got1.ex), 32'hC);

      // writes to r0 are dropped
      drive(NOP, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      drive(rtype(5'd0, 5'd0, 5'd1), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("r0.rd1", got1.rd1, 32'd0);

      // same-cycle write of r7 while decoding rs=7
      drive(NOP, 1'b0, 1'b1, 5'd7, 32'h0000_0055);
      tick();
      drive(rtype(5'd7, 5'd7, 5'd2), 1'b0, 1'b1, 5'd7, 32'h0000_1234);
      tick();
      cmp("bypass1.rd1", got1.rd1, 32'h0000_1234);
      cmp("bypass0.rd1", got0.rd1, 32'h0000_0055);

      // lw rt=8 with negative imm, then dependent add -> one bubble
      drive(itype(6'h23, 5'd0, 5'd8, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("lw.imm", got1.imm, 32'hFFFF_8000);
      cmp("lw.wb",  32'(got1.wb), 32'd3);
      cmp("lw.m",   32'(got1.m),  32'd2);
      cmp("lw.ex",  32'(got1.ex), 32'd1);
      drive(rtype(5'd8, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 32'd0);
      #1;
      cmp("loaduse.stall", 32'(bus1.stall), 32'd1);
      tick();
      cmp("bubble.ctrl", 32'({got1.wb, got1.m, got1.ex}), 32'd0);
      cmp("bubble.stall_clear", 32'(bus1.stall), 32'd0);
      tick();
      cmp("after_bubble.wb", 32'(got1.wb), 32'd2);
      cmp("after_bubble.ex", 32'(got1.ex), 32'hC);

      // lw to r0 never stalls
      drive(itype(6'h23, 5'd0, 5'd0, 16'h0004), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      drive(rtype(5'd0, 5'd0, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0);
      #1;
      cmp("lw_r0.stall", 32'(bus1.stall), 32'd0);
      tick();

      // branch taken flushes a sw
      drive(itype(6'h2B, 5'd1, 5'd2, 16'h0004), 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("flush.ctrl", 32'({got1.wb, got1.m, got1.ex}), 32'd0);
      drive(itype(6'h04, 5'd1, 5'd2, 16'hFFFC), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("beq.m",   32'(got1.m),  32'd4);
      cmp("beq.ex",  32'(got1.ex), 32'd2);
      cmp("beq.imm", got1.imm, 32'hFFFF_FFFC);

      // flush coinciding with a load-use stall
      drive(itype(6'h23, 5'd0, 5'd9, 16'h0010), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      drive(rtype(5'd9, 5'd9, 5'd1), 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("flush_stall.ctrl", 32'({got1.wb, got1.m, got1.ex}), 32'd0);
      drive(itype(6'h05, 5'd3, 5'd4, 16'h1111), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("unknown_op.ctrl", 32'({got1.wb, got1.m, got1.ex}), 32'd0);

      // mid-stream async reset while a stall is live and a write is pending
      drive(itype(6'h23, 5'd0, 5'd12, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      drive(rtype(5'd12, 5'd5, 5'd6), 1'b0, 1'b1, 5'd11, 32'h0000_0099);
      #1;
      cmp("pre_reset.stall", 32'(bus1.stall), 32'd1);
      rst = 1'b1;
      #1;
      cmp("async_reset.all_zero", 32'(|got1), 32'd0);
      cmp("async_reset.stall",    32'(bus1.stall), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      drive(rtype(5'd11, 5'd5, 5'd6), 1'b0, 1'b0, 5'd0, 32'd0);
      tick();
      cmp("post_reset.rd1_r11", got1.rd1, 32'd0);
      cmp("post_reset.rd2_r5",  got1.rd2, 32'd0);
      cmp("post_reset.wb",      32'(got1.wb), 32'd2);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i_decode.md
I_DECODE -- requirements
Module: i_decode

Interface
REQ-001 Parameter BYPASS, default 1: when 1, a read of the register being written in the same cycle returns the write data.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 IF_ID_INSTR  input  32  instruction from fetch stage IF/ID register.
REQ-005 IF_ID_NPC  input  32  PC+4 from fetch stage IF/ID register.
REQ-006 EX_MEM_PCSrc  input  1  branch taken; flushes this stage's output.
REQ-007 MEM_WB_RegWrite  input  1  writeback enable.
REQ-008 MEM_WB_WriteReg  input  5  writeback register index.
REQ-009 MEM_WB_WriteData  input  32  writeback data.
REQ-010 ID_EX_NPC  output  32  registered NPC.
REQ-011 ID_EX_RD1 / ID_EX_RD2  output  32 each  registered rs/rt operand values.
REQ-012 ID_EX_IMM  output  32  registered sign-extended instr[15:0].
REQ-013 ID_EX_RT / ID_EX_RD  output  5 each  registered instr[20:16] / instr[15:11].
REQ-014 ID_EX_WB  output  2  {RegWrite, MemtoReg}.
REQ-015 ID_EX_M  output  3  {Branch, MemRead, MemWrite}.
REQ-016 ID_EX_EX  output  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-017 Stall  output  1  combinational; holds PC and IF/ID when high.

Function
REQ-018 Register file: 32 x 32-bit; reads combinational on rs=instr[25:21], rt=instr[20:16].
REQ-019 Register 0 always reads 0; writes to index 0 are ignored.
REQ-020 Write on rising CLK when MEM_WB_RegWrite=1 and MEM_WB_WriteReg!=0.
REQ-021 BYPASS=1: same-cycle write to rs/rt index (nonzero) forwards MEM_WB_WriteData to RD1/RD2 inputs; BYPASS=0: old value read.
REQ-022 Decode on opcode instr[31:26], {WB,M,EX} bits: 0x00 R-type -> WB=10, M=000, EX=1100; 0x23 lw -> WB=11, M=010, EX=0001; 0x2B sw -> WB=00, M=001, EX=0001; 0x04 beq -> WB=00, M=100, EX=0010.
REQ-023 Any other opcode decodes as NOP: all control bits 0.
REQ-024 IMM = {16{instr[15]}, instr[15:0]}.
REQ-025 Load-use hazard: Stall=1 when ID_EX_M[1]=1 and ID_EX_RT!=0 and ID_EX_RT equals rs or rt of IF_ID_INSTR.
REQ-026 When Stall=1, next edge loads ID_EX_WB/M/EX with 0 (bubble); data fields may load normally.
REQ-027 When EX_MEM_PCSrc=1, next edge loads ID_EX_WB/M/EX with 0, overriding decode and stall.
REQ-028 Otherwise all ID_EX outputs load decoded values every rising edge; latency IF/ID to ID/EX = 1 cycle.
REQ-029 Register-file writes proceed regardless of Stall or EX_MEM_PCSrc.
REQ-030 Stall is purely combinational from current ID_EX state and IF_ID_INSTR; it does not depend on EX_MEM_PCSrc.

Reset
REQ-031 RST=1 asynchronously clears all ID_EX outputs to 0 and all 32 registers to 0.
REQ-032 RST asserted mid-operation discards any pending write that cycle; Stall reads 0 while RST=1.
REQ-033 First rising edge after RST deassert performs normal decode.

Verification
REQ-034 Write r5=0x0000_00AA, then R-type add rs=5 rt=0 -> next edge ID_EX_RD1=0xAA, RD2=0, WB=10, EX=1100.
REQ-035 Write r0=0xFFFF_FFFF, then read r0 -> RD1=0.
REQ-036 Same-cycle write r7=0x1234 while decoding instr with rs=7, BYPASS=1 -> ID_EX_RD1=0x1234; BYPASS=0 -> old r7 value.
REQ-037 lw to rt=8, then next instr add rs=8 -> Stall=1 for one cycle, bubble (WB=M=EX=0) in ID/EX, then add decodes normally.
REQ-038 EX_MEM_PCSrc=1 with sw in IF/ID -> next edge ID_EX_M=000, WB=00, EX=0000.
REQ-039 lw imm=0x8000 -> ID_EX_IMM=0xFFFF_8000; assert RST mid-stream -> all outputs 0 immediately, without waiting for CLK.
